seq_mult: RTL
=============

Name: seq_mult

Overview:
Parametrised iterative shift-add multiplier for the CPU's MULT/MULTU path. Supports signed and unsigned modes and configurable operand width. Retires BITS_PER_CYCLE multiplier bits per clock. Uses a start/busy/done handshake so the pipeline can stall on busy and capture the product on done into HI/LO.

Parameters:
WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
BITS_PER_CYCLE, 1, multiplier bits consumed per iteration; must be 1, 2 or 4 and must divide WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
start  input  1  request; accepted only when busy=0.
is_signed  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with start.
a  input  WIDTH  multiplicand; sampled with start.
b  input  WIDTH  multiplier; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; z is valid from that cycle on.
z  output  2*WIDTH  product; holds its value until the next result is written.

Behaviour:
- Let N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, BUSY, DONE. All registers are updated only on the rising edge of clk.
- Reset (reset=1 at an edge) overrides everything:
  - state goes to IDLE; z=0, busy=0, done=0; internal accumulator and counter are cleared.
  - Reset mid-operation aborts the operation. No done pulse follows.
- IDLE:
  - start=1 at an edge latches a, b and is_signed, loads the counter with N, and moves to BUSY with busy=1.
  - start=0: remain in IDLE.
- Operand conditioning at accept:
  - Signed mode: magnitudes |a| and |b| are latched as WIDTH-bit unsigned values, and result sign = a[MSB] XOR b[MSB].
  - The most-negative value maps to 2^(WIDTH-1), which fits the unsigned WIDTH-bit field.
  - Unsigned mode: operands are used as-is, and result sign = 0.
- BUSY, each edge:
  - The accumulator adds the multiplicand times the low BITS_PER_CYCLE bits of the multiplier field.
  - The accumulator then shifts right by BITS_PER_CYCLE.
  - The accumulator is wide enough (2*WIDTH+BITS_PER_CYCLE bits) that no carry is lost.
  - The counter decrements.
- On the edge where the counter reaches 0:
  - z is written with the product, two's-complement negated over 2*WIDTH bits when result sign = 1.
  - state goes to DONE; busy=0, done=1.
- Latency: with start accepted at edge E, done=1 and z is valid in the cycle after edge E+N. For WIDTH=32, BITS_PER_CYCLE=1 that is 32 edges.
- DONE lasts exactly one cycle:
  - start=1 at that edge is accepted immediately (back-to-back), moving to BUSY and loading the new operands.
  - Otherwise the block returns to IDLE. done is deasserted either way.
- start while busy=1 is ignored: operands are not re-sampled and the operation in flight is unaffected.
- Zero operands still take the full N cycles; there is no early termination.
- Arithmetic results, given as 2*WIDTH-bit two's complement:
  - signed 0x80000000*0x80000000 = 0x4000000000000000
  - signed -1*-1 = 1
  - unsigned 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001

Test Plan:
- Unsigned 3*5 (WIDTH=32, BITS_PER_CYCLE=1): start one cycle -> busy high for 32 cycles, done pulses once for one cycle, z=0x000000000000000F, z holds afterwards.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> z=0xFFFFFFFE00000001.
- Signed corner cases:
  - -3*5 -> z=0xFFFFFFFFFFFFFFF1
  - -1*-1 -> z=0x0000000000000001
  - 0x80000000*0x80000000 -> z=0x4000000000000000
  - 0x80000000*1 -> z=0xFFFFFFFF80000000
- Handshake:
  - Changing a/b and pulsing start while busy -> ignored, result from the original operands.
  - Start asserted in the done cycle -> new operation begins, busy the next cycle, second done 32 cycles later.
- Reset mid-operation at iteration 10 -> next cycle busy=0, done=0, z=0, and no done pulse ever appears. A subsequent 7*6 returns 42.
- BITS_PER_CYCLE=4, WIDTH=32: random signed/unsigned operand pairs vs reference model -> every result matches, and done arrives 8 edges after the start edge.

Source files
------------

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier for MULT/MULTU, retiring BITS_PER_CYCLE multiplier bits per clock.
// Signed operands are reduced to magnitudes on accept; the sign is reapplied when z is written.
module seq_mult #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned AccW = 2 * WIDTH + BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [2*WIDTH-1:0]  z_q, z_d;

  logic                load;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [AccW-1:0]     partial;
  logic [AccW-1:0]     acc_sum;
  logic [AccW-1:0]     acc_shift;
  logic [2*WIDTH-1:0]  prod;

  // The most-negative value negates to itself, which is exactly 2^(WIDTH-1) read as unsigned.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // Partial products enter at bit WIDTH; after N right shifts digit i lands at i*BITS_PER_CYCLE.
  always_comb begin
    partial = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier_q[i]) begin
        partial = partial + ({{(AccW - WIDTH){1'b0}}, mcand_q} << (WIDTH + i));
      end
    end
  end

  assign acc_sum   = acc_q + partial;
  assign acc_shift = acc_sum >> BITS_PER_CYCLE;
  assign prod      = acc_shift[2*WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    z_d      = z_q;
    load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          load = 1'b1;
        end
      end
      StBusy: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          z_d     = neg_q ? -prod : prod;
          state_d = StDone;
        end
      end
      StDone: begin
        if (start) begin
          load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      acc_d    = '0;
      mcand_d  = a_mag;
      mplier_d = b_mag;
      cnt_d    = CntW'(N);
      neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      state_d  = StBusy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      z_q      <= z_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign done = (state_q == StDone);
  assign z    = z_q;

endmodule
